// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 set-2 constants, event record and decoder state encoding.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam int unsigned EV_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_event_t;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StAck
  } dec_state_e;

endpackage

// File: rtl/ps2_key_event_decoder_if.sv
// Receiver-side handshake, event FIFO head and status bundle of the key event decoder.
interface ps2_key_event_decoder_if #(
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned MAX_HELD = 4
);
  localparam int unsigned HeldW = $clog2(MAX_HELD + 1);

  logic [7:0]         rx_data;
  logic               rx_ready;
  logic               rx_nextdata_n;
  logic               rx_overflow;
  logic               ev_valid;
  logic [7:0]         ev_code;
  logic               ev_ext;
  logic               ev_break;
  logic               ev_rd;
  logic [COUNT_W-1:0] key_count;
  logic [7:0]         cur_key;
  logic [HeldW-1:0]   held_count;
  logic               overflow;

  modport master (
    output rx_data, rx_ready, rx_overflow, ev_rd,
    input  rx_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, key_count, cur_key,
           held_count, overflow
  );

  modport slave (
    input  rx_data, rx_ready, rx_overflow, ev_rd,
    output rx_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, key_count, cur_key,
           held_count, overflow
  );
endinterface

// File: rtl/kbd_event_fifo.sv
// Show-ahead event FIFO; a push into a full FIFO is dropped unless a pop frees a slot.
module kbd_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 set-2 scancode decoder: prefix FSM, held-key table for repeat suppression, event FIFO.
module ps2_key_event_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned COUNT_W    = 8,
  parameter int unsigned MAX_HELD   = 4
) (
  input logic                  clk,
  input logic                  clrn,
  ps2_key_event_decoder_if.slave bus
);
  localparam int unsigned HeldW = $clog2(MAX_HELD + 1);

  dec_state_e         state_q, ret_q, ret_d;
  logic               take, in_ext, in_brk, ev_done, ev_fire, push;
  logic               fifo_empty, fifo_full, fifo_drop;
  logic [EV_W-1:0]    fifo_rdata;
  kbd_event_t         ev, head;
  logic [MAX_HELD-1:0] held_vld_q, held_vld_d, hit, free_oh;
  logic [8:0]         held_key_q [MAX_HELD];
  logic [8:0]         held_key_d [MAX_HELD];
  logic [COUNT_W-1:0] key_count_q, key_count_d;
  logic [7:0]         cur_key_q, cur_key_d;
  logic               overflow_q;
  logic [HeldW-1:0]   held_cnt;

  // Prefix decode of the byte on offer; only acted on when take is high.
  always_comb begin
    take    = bus.rx_ready && (state_q != StAck);
    in_ext  = (state_q == StExt) || (state_q == StExtBrk);
    in_brk  = (state_q == StBrk) || (state_q == StExtBrk);
    ret_d   = StIdle;
    ev_done = 1'b0;
    if (bus.rx_data == SC_EXT && (state_q == StIdle || state_q == StExt)) begin
      ret_d = StExt;
    end else if (bus.rx_data == SC_BRK) begin
      ret_d = in_ext ? StExtBrk : StBrk;
    end else begin
      ev_done = 1'b1;
    end
    ev.ext  = in_ext;
    ev.brk  = in_brk;
    ev.code = bus.rx_data;
  end

  assign ev_fire           = take && ev_done;
  assign bus.rx_nextdata_n = ~take;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      ret_q   <= StIdle;
    end else if (state_q == StAck) begin
      state_q <= ret_q;
    end else if (take) begin
      state_q <= StAck;
      ret_q   <= ret_d;
    end
  end

  // Lowest empty slot, one-hot; zero when the table is full.
  assign free_oh = ~held_vld_q & (held_vld_q + MAX_HELD'(1));

  always_comb begin
    hit = '0;
    for (int i = 0; i < MAX_HELD; i++) begin
      hit[i] = held_vld_q[i] && (held_key_q[i] == {ev.ext, ev.code});
    end
  end

  assign push = ev_fire && (ev.brk || !(|hit));

  always_comb begin
    held_vld_d  = held_vld_q;
    held_key_d  = held_key_q;
    key_count_d = key_count_q;
    cur_key_d   = cur_key_q;
    if (ev_fire) begin
      if (!ev.brk) begin
        if (!(|hit)) begin
          key_count_d = key_count_q + 1'b1;
          cur_key_d   = ev.code;
          for (int i = 0; i < MAX_HELD; i++) begin
            if (free_oh[i]) begin
              held_vld_d[i] = 1'b1;
              held_key_d[i] = {ev.ext, ev.code};
            end
          end
        end
      end else begin
        held_vld_d = held_vld_q & ~hit;
        if ((|hit) && ev.code == cur_key_q) cur_key_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      held_vld_q  <= '0;
      for (int i = 0; i < MAX_HELD; i++) held_key_q[i] <= '0;
      key_count_q <= '0;
      cur_key_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      held_vld_q  <= held_vld_d;
      held_key_q  <= held_key_d;
      key_count_q <= key_count_d;
      cur_key_q   <= cur_key_d;
      overflow_q  <= overflow_q | bus.rx_overflow | fifo_drop;
    end
  end

  always_comb begin
    held_cnt = '0;
    for (int i = 0; i < MAX_HELD; i++) held_cnt = held_cnt + HeldW'(held_vld_q[i]);
  end

  kbd_event_fifo #(
    .WIDTH(EV_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .clrn   (clrn),
    .push_i (push),
    .data_i (ev),
    .pop_i  (bus.ev_rd),
    .data_o (fifo_rdata),
    .empty_o(fifo_empty),
    .full_o (fifo_full),
    .drop_o (fifo_drop)
  );

  assign head           = kbd_event_t'(fifo_rdata);
  assign bus.ev_valid   = ~fifo_empty;
  assign bus.ev_code    = head.code;
  assign bus.ev_ext     = head.ext;
  assign bus.ev_break   = head.brk;
  assign bus.key_count  = key_count_q;
  assign bus.cur_key    = cur_key_q;
  assign bus.held_count = held_cnt;
  assign bus.overflow   = overflow_q;

endmodule
